// File: rtl/digital_lock_top.sv
// Four-button combination lock: debounced digit entry, compare against a fixed
// code, and show the result on a multiplexed 4-digit 7-segment display and LEDs.
module digital_lock_top #(
    parameter logic [7:0] SECRET          = 8'b10_00_11_01,
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         REFRESH_DIV     = 1024,
    parameter int         HOLD_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] button,
    output logic [6:0] ssd,
    output logic [3:0] dig,
    output logic [3:0] led
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RF_W   = $clog2(REFRESH_DIV + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_ERROR} state_t;

    logic [3:0] press_pulse;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic            sync1_reg, sync2_reg, deb_reg, press_reg;
            logic [DB_W-1:0] cnt_reg;

            // Debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= button[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_reg   <= sync2_reg;
                        press_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press_pulse[gi] = press_reg;
        end
    endgenerate

    logic       single_press;
    logic [1:0] press_digit;

    always_comb begin
        press_digit = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i]) press_digit = 2'(i);
        end
        single_press = $onehot(press_pulse);
    end

    state_t              state_reg;
    logic [2:0]          count_reg;
    logic [7:0]          entry_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            count_reg    <= 3'd0;
            entry_reg    <= 8'd0;
            hold_cnt_reg <= '0;
        end else begin
            unique case (state_reg)
                S_IDLE, S_ENTRY: begin
                    if (single_press) begin
                        // Digit n lives at [7-2n -: 2], so the first digit is the MSBs.
                        entry_reg[{~count_reg[1:0], 1'b0} +: 2] <= press_digit;
                        count_reg <= count_reg + 3'd1;
                        state_reg <= (count_reg == 3'd3) ? S_CHECK : S_ENTRY;
                    end
                end
                S_CHECK: begin
                    state_reg    <= (entry_reg == SECRET) ? S_OPEN : S_ERROR;
                    hold_cnt_reg <= '0;
                end
                S_OPEN, S_ERROR: begin
                    if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_reg <= S_IDLE;
                        count_reg <= 3'd0;
                        entry_reg <= 8'd0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] digit_seg(input logic [1:0] d);
        case (d)
            2'd0:    digit_seg = SEG_0;
            2'd1:    digit_seg = SEG_1;
            2'd2:    digit_seg = SEG_2;
            default: digit_seg = SEG_3;
        endcase
    endfunction

    function automatic logic [6:0] pos_char(input state_t st, input logic [1:0] p,
                                            input logic [2:0] cnt, input logic [7:0] code);
        if (st == S_OPEN) begin
            case (p)
                2'd3:    pos_char = SEG_O;
                2'd2:    pos_char = SEG_P;
                2'd1:    pos_char = SEG_E;
                default: pos_char = SEG_N;
            endcase
        end else if (st == S_ERROR) begin
            case (p)
                2'd3:    pos_char = SEG_E;
                2'd2:    pos_char = SEG_R;
                2'd1:    pos_char = SEG_R;
                default: pos_char = SEG_BLANK;
            endcase
        end else if ({1'b0, ~p} < cnt) begin
            // Position p shows digit 3-p, which is stored at bits [2p+1:2p].
            pos_char = digit_seg(code[{p, 1'b0} +: 2]);
        end else begin
            pos_char = SEG_DASH;
        end
    endfunction

    logic [RF_W-1:0] refresh_cnt_reg;
    logic [1:0]      pos_reg;
    logic            wrap;
    logic [1:0]      pos_next;

    always_comb begin
        wrap     = (refresh_cnt_reg == RF_W'(REFRESH_DIV - 1));
        pos_next = wrap ? pos_reg + 2'd1 : pos_reg;
    end

    // dig and ssd are both derived from pos_next so they stay aligned on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_reg <= '0;
            pos_reg         <= 2'd0;
            dig             <= 4'b1110;
            ssd             <= SEG_DASH;
            led             <= 4'b0000;
        end else begin
            refresh_cnt_reg <= wrap ? '0 : refresh_cnt_reg + 1'b1;
            pos_reg         <= pos_next;
            dig             <= ~(4'b0001 << pos_next);
            ssd             <= pos_char(state_reg, pos_next, count_reg, entry_reg);
            case (state_reg)
                S_OPEN:  led <= 4'b1111;
                S_ERROR: led <= 4'b1001;
                default: led <= 4'((5'd1 << count_reg) - 5'd1);
            endcase
        end
    end
endmodule

// File: tb/tb_digital_lock_top.sv
// Randomized bench for digital_lock_top against a queue-style model of the lock:
// a list of entered digits plus an idle/open/error mode.
module tb_digital_lock_top;
    localparam int DB = 4;
    localparam int RD = 4;
    localparam int HC = 64;

    localparam logic [6:0] C_DASH  = 7'b0111111;
    localparam logic [6:0] C_BLANK = 7'b1111111;
    localparam logic [6:0] C_O     = 7'b1000000;
    localparam logic [6:0] C_P     = 7'b0001100;
    localparam logic [6:0] C_E     = 7'b0000110;
    localparam logic [6:0] C_N     = 7'b0101011;
    localparam logic [6:0] C_R     = 7'b0101111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] button = 4'd0;
    logic [6:0] ssd;
    logic [3:0] dig;
    logic [3:0] led;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_digit [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
    int secret_q [4] = '{2, 0, 3, 1};

    // Model: entered digits in order, and mode 0=idle/entry, 1=open, 2=error.
    int n_dig = 0;
    int dig_q [4] = '{0, 0, 0, 0};
    int mode = 0;

    always #5 clk = ~clk;

    digital_lock_top #(
        .SECRET(8'b10_00_11_01),
        .DEBOUNCE_CYCLES(DB),
        .REFRESH_DIV(RD),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .button(button),
        .ssd(ssd),
        .dig(dig),
        .led(led)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_led();
        logic [3:0] r;
        r = 4'b0000;
        if (mode == 1) r = 4'b1111;
        else if (mode == 2) r = 4'b1001;
        else for (int i = 0; i < n_dig; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Packed as {pos3, pos2, pos1, pos0}; entered digit k appears at position 3-k.
    function automatic logic [27:0] exp_disp();
        logic [27:0] r;
        if (mode == 1) r = {C_O, C_P, C_E, C_N};
        else if (mode == 2) r = {C_E, C_R, C_R, C_BLANK};
        else begin
            r = '0;
            for (int k = 0; k < 4; k++)
                r[(3 - k) * 7 +: 7] = (k < n_dig) ? seg_digit[dig_q[k]] : C_DASH;
        end
        return r;
    endfunction

    task automatic capture(output logic [27:0] d);
        d = '0;
        repeat (20) begin
            @(negedge clk);
            case (dig)
                4'b1110: d[6:0]   = ssd;
                4'b1101: d[13:7]  = ssd;
                4'b1011: d[20:14] = ssd;
                4'b0111: d[27:21] = ssd;
                default: ;
            endcase
        end
    endtask

    task automatic model_press(input logic [3:0] mask);
        bit match;
        int idx;
        if (mode == 0 && $countones(mask) == 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (mask[i]) idx = i;
            dig_q[n_dig] = idx;
            n_dig++;
            if (n_dig == 4) begin
                match = 1'b1;
                for (int i = 0; i < 4; i++) if (dig_q[i] != secret_q[i]) match = 1'b0;
                mode = match ? 1 : 2;
            end
        end
    endtask

    task automatic do_press(input logic [3:0] mask);
        button = mask;
        repeat (10) @(negedge clk);
        button = 4'd0;
        repeat (10) @(negedge clk);
        model_press(mask);
    endtask

    task automatic check_state(input string tag);
        logic [27:0] d;
        check_val({tag, "_led"}, 32'(led), 32'(exp_led()));
        capture(d);
        check_val({tag, "_disp"}, 32'(d), 32'(exp_disp()));
    endtask

    task automatic press_and_check(input logic [3:0] mask, input string tag);
        do_press(mask);
        $display("press mask=%b led=%b mode=%0d digits=%0d", mask, led, mode, n_dig);
        check_state(tag);
        if (mode != 0) begin
            do_press(4'(1 << $urandom_range(0, 3)));
            check_val({tag, "_hold_led"}, 32'(led), 32'(exp_led()));
            repeat (30) @(negedge clk);
            mode = 0;
            n_dig = 0;
            check_state({tag, "_after_hold"});
        end
    endtask

    initial begin
        logic [27:0] d;
        logic [3:0]  mask;
        int          dd;
        bit          aim;

        repeat (2) @(negedge clk);
        check_val("rst_led", 32'(led), 32'(4'b0000));
        check_val("rst_dig", 32'(dig), 32'(4'b1110));
        check_val("rst_ssd", 32'(ssd), 32'(C_DASH));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("dig_before_wrap", 32'(dig), 32'(4'b1110));
        @(negedge clk);
        check_val("dig_after_wrap", 32'(dig), 32'(4'b1101));
        check_state("idle");

        press_and_check(4'b0100, "open_d0");
        press_and_check(4'b0001, "open_d1");
        press_and_check(4'b1000, "open_d2");
        press_and_check(4'b0010, "open_d3");

        for (int i = 0; i < 4; i++) press_and_check(4'b0010, "err");

        press_and_check(4'b0110, "double");

        // Bounce on button[0]: 2-cycle runs never satisfy the debounce window.
        button = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            repeat (2) @(negedge clk);
            button[0] = ~button[0];
        end
        press_and_check(4'b0001, "bounce");
        capture(d);
        check_val("bounce_pos3", 32'(d[27:21]), 32'(7'b1000000));

        press_and_check(4'b1000, "pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_led", 32'(led), 32'(4'b0000));
        check_val("midrst_dig", 32'(dig), 32'(4'b1110));
        check_val("midrst_ssd", 32'(ssd), 32'(C_DASH));
        @(negedge clk);
        rst_n = 1'b1;
        n_dig = 0;
        mode = 0;
        check_state("post_reset");

        aim = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if (n_dig == 0) aim = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) begin
                do mask = 4'($urandom_range(3, 15)); while ($countones(mask) < 2);
            end else begin
                dd = aim ? secret_q[n_dig] : int'($urandom_range(0, 3));
                mask = 4'(1 << dd);
            end
            press_and_check(mask, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
